// File: rtl/rom_arbiter.sv
// Two-master arbiter sharing a single-port instruction memory between the
// fetch port (m0, read-only) and the loader/debug port (m1, read/write).
module rom_arbiter #(
  parameter int unsigned DEPTH = 4096
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        m0_req_i,
  input  logic [31:0] m0_addr_i,
  output logic        m0_ready_o,
  output logic        m0_rvalid_o,
  output logic [31:0] m0_rdata_o,
  output logic        m0_err_o,

  input  logic        m1_req_i,
  input  logic        m1_we_i,
  input  logic        m1_lock_i,
  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m1_wdata_i,
  output logic        m1_ready_o,
  output logic        m1_rvalid_o,
  output logic [31:0] m1_rdata_o,
  output logic        m1_err_o,

  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i
);

  localparam logic [31:0] DepthW = 32'(DEPTH);

  typedef enum logic {
    ST_IDLE,
    ST_LOCKED
  } state_e;

  state_e      state_q, state_d;
  logic        last_grant_q, last_grant_d;   // 0 = m0, 1 = m1

  logic        m0_rvalid_q, m0_rvalid_d;
  logic [31:0] m0_rdata_q, m0_rdata_d;
  logic        m0_err_q, m0_err_d;
  logic        m1_rvalid_q, m1_rvalid_d;
  logic [31:0] m1_rdata_q, m1_rdata_d;
  logic        m1_err_q, m1_err_d;

  logic        gnt0, gnt1;
  logic        m0_in_range, m1_in_range;

  assign m0_in_range = {2'b00, m0_addr_i[31:2]} < DepthW;
  assign m1_in_range = {2'b00, m1_addr_i[31:2]} < DepthW;

  // Grants double as ready; reset masks them so nothing is accepted mid-reset.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst) begin
      if (state_q == ST_LOCKED) begin
        gnt1 = m1_req_i;
      end else if (m0_req_i && m1_req_i) begin
        gnt0 = last_grant_q;
        gnt1 = !last_grant_q;
      end else begin
        gnt0 = m0_req_i;
        gnt1 = m1_req_i;
      end
    end
  end

  assign m0_ready_o = gnt0;
  assign m1_ready_o = gnt1;

  always_comb begin
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (gnt0) begin
      mem_addr_o = m0_addr_i;
    end else if (gnt1) begin
      mem_addr_o  = m1_addr_i;
      mem_wdata_o = m1_wdata_i;
      mem_we_o    = m1_we_i && m1_in_range;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    if (gnt0) last_grant_d = 1'b0;
    else if (gnt1) last_grant_d = 1'b1;

    case (state_q)
      ST_IDLE:   if (gnt1 && m1_lock_i) state_d = ST_LOCKED;
      ST_LOCKED: if (!m1_lock_i) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Response data is captured at acceptance; idle cycles hold zero.
  always_comb begin
    m0_rvalid_d = gnt0;
    m0_err_d    = gnt0 && !m0_in_range;
    m0_rdata_d  = (gnt0 && m0_in_range) ? mem_rdata_i : '0;
    m1_rvalid_d = gnt1;
    m1_err_d    = gnt1 && !m1_in_range;
    m1_rdata_d  = (gnt1 && m1_in_range && !m1_we_i) ? mem_rdata_i : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      m0_rvalid_q  <= 1'b0;
      m0_rdata_q   <= '0;
      m0_err_q     <= 1'b0;
      m1_rvalid_q  <= 1'b0;
      m1_rdata_q   <= '0;
      m1_err_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      m0_rvalid_q  <= m0_rvalid_d;
      m0_rdata_q   <= m0_rdata_d;
      m0_err_q     <= m0_err_d;
      m1_rvalid_q  <= m1_rvalid_d;
      m1_rdata_q   <= m1_rdata_d;
      m1_err_q     <= m1_err_d;
    end
  end

  assign m0_rvalid_o = m0_rvalid_q;
  assign m0_rdata_o  = m0_rdata_q;
  assign m0_err_o    = m0_err_q;
  assign m1_rvalid_o = m1_rvalid_q;
  assign m1_rdata_o  = m1_rdata_q;
  assign m1_err_o    = m1_err_q;

endmodule

// File: tb/tb_rom_arbiter.sv
// Directed bench for rom_arbiter with a behavioural 4096-word memory behind it.
module tb_rom_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req_i, m1_req_i, m1_we_i, m1_lock_i;
  logic [31:0] m0_addr_i, m1_addr_i, m1_wdata_i;
  logic        m0_ready_o, m0_rvalid_o, m0_err_o;
  logic        m1_ready_o, m1_rvalid_o, m1_err_o;
  logic [31:0] m0_rdata_o, m1_rdata_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;

  logic [31:0] mem [0:4095];
  int unsigned n_chk = 0;
  int unsigned n_bad = 0;

  always #5 clk = ~clk;

  rom_arbiter #(.DEPTH(4096)) dut (
    .clk(clk), .rst(rst),
    .m0_req_i(m0_req_i), .m0_addr_i(m0_addr_i), .m0_ready_o(m0_ready_o),
    .m0_rvalid_o(m0_rvalid_o), .m0_rdata_o(m0_rdata_o), .m0_err_o(m0_err_o),
    .m1_req_i(m1_req_i), .m1_we_i(m1_we_i), .m1_lock_i(m1_lock_i),
    .m1_addr_i(m1_addr_i), .m1_wdata_i(m1_wdata_i), .m1_ready_o(m1_ready_o),
    .m1_rvalid_o(m1_rvalid_o), .m1_rdata_o(m1_rdata_o), .m1_err_o(m1_err_o),
    .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata_i)
  );

  assign mem_rdata_i = mem[mem_addr_o[13:2]];

  always @(posedge clk) begin
    if (mem_we_o) mem[mem_addr_o[13:2]] <= mem_wdata_o;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 32'(i) ^ 32'h5A00_0000;
    mem[0]    = 32'h0BAD_0000;
    mem[4]    = 32'hDEAD_BEEF;
    mem[5]    = 32'h5555_5555;
    mem[4095] = 32'h0FFF_0FFF;

    rst = 1'b1;
    m0_req_i = 1'b1; m0_addr_i = 32'h10;
    m1_req_i = 1'b1; m1_we_i = 1'b1; m1_lock_i = 1'b0;
    m1_addr_i = 32'h20; m1_wdata_i = 32'hFFFF_FFFF;

    // reset state: readies and write enable held low
    @(negedge clk); @(negedge clk); #1;
    chk("rst_ready0", 32'(m0_ready_o), 32'd0);
    chk("rst_ready1", 32'(m1_ready_o), 32'd0);
    chk("rst_we", 32'(mem_we_o), 32'd0);
    chk("rst_rvalid0", 32'(m0_rvalid_o), 32'd0);
    chk("rst_rdata1", m1_rdata_o, 32'd0);
    chk("rst_err1", 32'(m1_err_o), 32'd0);

    // single m0 read of word 4
    @(negedge clk);
    rst = 1'b0; m1_req_i = 1'b0; m1_we_i = 1'b0;
    #1;
    chk("rd_ready0", 32'(m0_ready_o), 32'd1);
    chk("rd_ready1", 32'(m1_ready_o), 32'd0);
    chk("rd_addr", mem_addr_o, 32'h10);
    @(negedge clk); m0_req_i = 1'b0; #1;
    chk("rd_rvalid0", 32'(m0_rvalid_o), 32'd1);
    chk("rd_rdata0", m0_rdata_o, 32'hDEAD_BEEF);
    chk("rd_err0", 32'(m0_err_o), 32'd0);
    chk("rd_rvalid1", 32'(m1_rvalid_o), 32'd0);

    // fresh reset, then six cycles of contention: m0,m1,m0,m1,m0,m1
    @(negedge clk); rst = 1'b1; #1;
    @(negedge clk);
    rst = 1'b0;
    m0_req_i = 1'b1; m0_addr_i = 32'h10;
    m1_req_i = 1'b1; m1_we_i = 1'b0; m1_addr_i = 32'h14;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      chk("rr_ready0", 32'(m0_ready_o), (i % 2 == 0) ? 32'd1 : 32'd0);
      chk("rr_ready1", 32'(m1_ready_o), (i % 2 == 0) ? 32'd0 : 32'd1);
      if (i > 0) begin
        chk("rr_rvalid0", 32'(m0_rvalid_o), (i % 2 == 1) ? 32'd1 : 32'd0);
        chk("rr_rvalid1", 32'(m1_rvalid_o), (i % 2 == 0) ? 32'd1 : 32'd0);
        if (i % 2 == 1) chk("rr_rdata0", m0_rdata_o, 32'hDEAD_BEEF);
        else            chk("rr_rdata1", m1_rdata_o, 32'h5555_5555);
      end
    end
    @(negedge clk); m0_req_i = 1'b0; m1_req_i = 1'b0; #1;
    chk("rr_last_rvalid1", 32'(m1_rvalid_o), 32'd1);
    chk("rr_last_rdata1", m1_rdata_o, 32'h5555_5555);
    chk("rr_last_rvalid0", 32'(m0_rvalid_o), 32'd0);

    // locked write + read by m1 while m0 keeps requesting
    @(negedge clk);
    m1_req_i = 1'b1; m1_we_i = 1'b1; m1_lock_i = 1'b1;
    m1_addr_i = 32'h40; m1_wdata_i = 32'h1234_5678;
    #1;
    chk("lk_ready1_wr", 32'(m1_ready_o), 32'd1);
    chk("lk_we", 32'(mem_we_o), 32'd1);
    chk("lk_wdata", mem_wdata_o, 32'h1234_5678);
    @(negedge clk);
    m0_req_i = 1'b1; m0_addr_i = 32'h10; m1_we_i = 1'b0;
    #1;
    chk("lk_ready0_a", 32'(m0_ready_o), 32'd0);
    chk("lk_ready1_rd", 32'(m1_ready_o), 32'd1);
    chk("lk_wack_rvalid1", 32'(m1_rvalid_o), 32'd1);
    chk("lk_wack_rdata1", m1_rdata_o, 32'd0);
    chk("lk_wack_err1", 32'(m1_err_o), 32'd0);
    @(negedge clk);
    m1_req_i = 1'b0; m1_lock_i = 1'b0;
    #1;
    chk("lk_ready0_b", 32'(m0_ready_o), 32'd0);
    chk("lk_rd_rvalid1", 32'(m1_rvalid_o), 32'd1);
    chk("lk_rd_rdata1", m1_rdata_o, 32'h1234_5678);
    chk("lk_rvalid0", 32'(m0_rvalid_o), 32'd0);
    @(negedge clk); #1;
    chk("lk_ready0_free", 32'(m0_ready_o), 32'd1);

    // lock asserted without an m1 acceptance must not lock out m0
    @(negedge clk); m1_lock_i = 1'b1; #1;
    chk("lk_ign_rdata0", m0_rdata_o, 32'hDEAD_BEEF);
    chk("lk_ign_ready0_a", 32'(m0_ready_o), 32'd1);
    @(negedge clk); #1;
    chk("lk_ign_ready0_b", 32'(m0_ready_o), 32'd1);
    @(negedge clk); m0_req_i = 1'b0; m1_lock_i = 1'b0; #1;
    chk("lk_ign_rvalid0", 32'(m0_rvalid_o), 32'd1);

    // out-of-range write, out-of-range read, last valid word
    @(negedge clk);
    m1_req_i = 1'b1; m1_we_i = 1'b1; m1_addr_i = 32'h4000; m1_wdata_i = 32'hFFFF_FFFF;
    #1;
    chk("oor_ready1", 32'(m1_ready_o), 32'd1);
    chk("oor_we", 32'(mem_we_o), 32'd0);
    @(negedge clk);
    m1_req_i = 1'b0; m0_req_i = 1'b1; m0_addr_i = 32'h4000;
    #1;
    chk("oor_rvalid1", 32'(m1_rvalid_o), 32'd1);
    chk("oor_err1", 32'(m1_err_o), 32'd1);
    chk("oor_rdata1", m1_rdata_o, 32'd0);
    @(negedge clk);
    m0_req_i = 1'b0; m1_req_i = 1'b1; m1_we_i = 1'b0; m1_addr_i = 32'h3FFC;
    #1;
    chk("oor_rvalid0", 32'(m0_rvalid_o), 32'd1);
    chk("oor_err0", 32'(m0_err_o), 32'd1);
    chk("oor_rdata0", m0_rdata_o, 32'd0);
    @(negedge clk); m1_req_i = 1'b0; #1;
    chk("top_err1", 32'(m1_err_o), 32'd0);
    chk("top_rdata1", m1_rdata_o, 32'h0FFF_0FFF);

    // write 0x1000 then read 0x1003: same word, new data
    @(negedge clk);
    m1_req_i = 1'b1; m1_we_i = 1'b1; m1_addr_i = 32'h1000; m1_wdata_i = 32'hA5A5_A5A5;
    @(negedge clk);
    m1_we_i = 1'b0; m1_addr_i = 32'h1003;
    @(negedge clk); m1_req_i = 1'b0; #1;
    chk("wr_rd_rvalid1", 32'(m1_rvalid_o), 32'd1);
    chk("wr_rd_rdata1", m1_rdata_o, 32'hA5A5_A5A5);

    // reset asserted while a response is pending clears it without an edge
    @(negedge clk);
    m0_req_i = 1'b1; m0_addr_i = 32'h10;
    @(posedge clk); #1;
    chk("mid_rvalid0_pre", 32'(m0_rvalid_o), 32'd1);
    rst = 1'b1; #1;
    chk("mid_rvalid0", 32'(m0_rvalid_o), 32'd0);
    chk("mid_rdata0", m0_rdata_o, 32'd0);
    chk("mid_ready0", 32'(m0_ready_o), 32'd0);
    @(negedge clk);
    rst = 1'b0; m1_req_i = 1'b1; m1_we_i = 1'b0; m1_addr_i = 32'h14;
    #1;
    chk("post_rst_ready0", 32'(m0_ready_o), 32'd1);
    chk("post_rst_ready1", 32'(m1_ready_o), 32'd0);
    @(negedge clk); m0_req_i = 1'b0; m1_req_i = 1'b0; #1;
    chk("post_rst_rdata0", m0_rdata_o, 32'hDEAD_BEEF);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/rom_arbiter.md
# rom_arbiter

Two-port arbiter that shares the single-port instruction memory between the core's instruction-fetch port (m0, read-only) and the program loader/debug port (m1, read/write). It sits between those requesters and the memory's we/addr/data pins. It provides per-master valid/ready request handshakes with a registered one-cycle read response, round-robin arbitration on contention, a loader lock for bulk download, and out-of-range address rejection.

## Interface
Parameters:
- DEPTH, 4096: memory depth in 32-bit words; valid word index range is 0..DEPTH-1.

Ports:
- clk  in  1  sole clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- m0_req_i  in  1  fetch request valid.
- m0_addr_i  in  32  fetch byte address; bits [1:0] ignored.
- m0_ready_o  out  1  fetch request accepted this cycle.
- m0_rvalid_o  out  1  fetch response valid.
- m0_rdata_o  out  32  fetch read data.
- m0_err_o  out  1  fetch response is an address error; qualified by m0_rvalid_o.
- m1_req_i  in  1  loader request valid.
- m1_we_i  in  1  loader write (1) or read (0).
- m1_lock_i  in  1  loader lock request.
- m1_addr_i  in  32  loader byte address; bits [1:0] ignored.
- m1_wdata_i  in  32  loader write data.
- m1_ready_o  out  1  loader request accepted this cycle.
- m1_rvalid_o  out  1  loader response/ack valid.
- m1_rdata_o  out  32  loader read data; 0 for writes.
- m1_err_o  out  1  loader address error; qualified by m1_rvalid_o.
- mem_we_o  out  1  memory write enable.
- mem_addr_o  out  32  memory byte address.
- mem_wdata_o  out  32  memory write data.
- mem_rdata_i  in  32  memory read data; combinational from mem_addr_o.

## Operation
- A request is accepted in a cycle when mX_req_i=1 and mX_ready_o=1. At most one ready is high per cycle. Ready is combinational from the requests and the arbiter state.
- Memory pins carry the granted master's request combinationally.
  - mem_addr_o: granted address.
  - mem_we_o: asserted only for an accepted, in-range m1 write.
  - When no master is granted: mem_we_o=0, mem_addr_o=0, mem_wdata_o=0.
- Range check: word index is addr[31:2]. A request with addr[31:2] >= DEPTH is accepted but does not write memory. Its response has err=1 and rdata=0.
- Arbitration state machine, states IDLE and LOCKED:
  - IDLE, single requester: that requester is granted.
  - IDLE, both requesting: the master not granted last (last_grant register) is granted. last_grant updates on every acceptance.
  - IDLE to LOCKED: on acceptance of an m1 request with m1_lock_i=1.
  - LOCKED: only m1 may be granted; m0_ready_o=0.
  - LOCKED to IDLE: at the first cycle edge where m1_lock_i=0. m0 becomes grantable in the following cycle.
- Response: one cycle after acceptance, the accepted master sees rvalid=1 for exactly one cycle.
  - Reads: rdata = mem_rdata_i sampled at acceptance.
  - Writes: rdata=0.
  - The non-accepted master's rvalid is 0.
- Responses cannot be back-pressured; requesters must always consume them. Back-to-back acceptances give back-to-back rvalid pulses.

## Timing
- Reset values (asynchronous, while rst=1): state=IDLE, last_grant=m1 (so m0 wins the first contention), all rvalid=0, all rdata=0, all err=0.
  - All ready outputs and mem_we_o are forced to 0 combinationally during reset.
- Latency: request to response is exactly 1 cycle. Throughput is 1 accepted request per cycle in aggregate.
- Reset mid-operation: a response due in the next cycle is dropped. LOCKED returns to IDLE.
- Locking during a simultaneous m0 request: the m1 lock takes effect only when m1 wins arbitration. m0 is not preempted in the cycle it is granted.
- m1_lock_i is ignored in IDLE unless m1 is accepted in that cycle.
- Write then read of the same address on consecutive cycles returns the new data. The memory write commits at the edge that accepts the write.
- Address bits [1:0]: 0x1003 and 0x1000 address the same word.

## Test plan
- Reset, then m0 reads 0x0000_0010 (word 4 = 0xDEADBEEF) -> m0_ready_o=1 in that cycle; next cycle m0_rvalid_o=1, m0_rdata_o=0xDEADBEEF, m0_err_o=0.
- Both masters request continuously for 6 cycles -> grants m0,m1,m0,m1,m0,m1; each rvalid arrives one cycle after its grant.
- m1 writes 0x1234_5678 to 0x40 with lock=1, then reads 0x40, then drops lock while m0 requests throughout -> m0_ready_o=0 until the cycle after lock drops; the m1 read returns 0x12345678.
- m1 writes to 0x0000_4000 (word 4096, DEPTH=4096) -> mem_we_o stays 0; next cycle m1_rvalid_o=1, m1_err_o=1, m1_rdata_o=0.
- Assert rst in the cycle after an m0 acceptance -> m0_rvalid_o=0 and m0_rdata_o=0 immediately, with no clock edge required; after release, the first contention goes to m0.
- m1 reads 0x1003 after writing 0xA5A5A5A5 to 0x1000 -> m1_rdata_o=0xA5A5A5A5.
